dmem_arbiter: RTL and testbench

- Shares the single-port, byte-wide data memory (64 bytes, big-endian word layout) between two requesters: the processor load/store port (cpu) and a loader/debug DMA port (dma).
- Serialises each 32-bit word access into four byte beats.
- Arbitrates the two requesters round-robin.
- Returns an assembled word and a one-cycle done pulse to the requester that owns the access.
- Sits between the processor datapath and the synchronous byte RAM.

---
 rtl/dmem_arbiter_pkg.sv | 31 +++
 rtl/dmem_arbiter_rr_arb2.sv | 27 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, owner codes,
// beat count and the byte-select helper used by the beat sequencer.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int BEATS = 4;

  // Big-endian byte select: beat 0 is the MSB byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the cpu, bit 1 the dma.
// On a tie the requester that was not served last wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant selection, suppressed when not enabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == OWN_CPU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a byte-wide synchronous RAM between the cpu
// and dma ports, serialising each 32-bit word into four MSB-first beats.
module dmem_arbiter #(
  parameter int AW    = 6,
  parameter int BEATS = dmem_arbiter_pkg::BEATS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [31:0]   cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [31:0]   dma_rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  import dmem_arbiter_pkg::*;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_e        state_r;
  logic [1:0]    beat_r;
  owner_e        owner_r;
  owner_e        last_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [23:0]   asm_r;
  logic [31:0]   cpu_rdata_r;
  logic [31:0]   dma_rdata_r;
  logic [1:0]    arb_gnt_s;
  logic [31:0]   word_s;

  rr_arb2 u_arb (
    .req  ({dma_req, cpu_req}),
    .last (last_r),
    .en   (state_r == ST_IDLE),
    .gnt  (arb_gnt_s)
  );

  // FSM, request latch, read assembly and per-port read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      beat_r      <= 2'd0;
      owner_r     <= OWN_CPU;
      last_r      <= OWN_DMA;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'h0;
      asm_r       <= 24'h0;
      cpu_rdata_r <= 32'h0;
      dma_rdata_r <= 32'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_gnt_s != 2'b00) begin
            state_r <= ST_ACCESS;
            beat_r  <= 2'd0;
            if (arb_gnt_s[1]) begin
              owner_r <= OWN_DMA;
              we_r    <= dma_we;
              addr_r  <= dma_addr;
              wdata_r <= dma_wdata;
            end else begin
              owner_r <= OWN_CPU;
              we_r    <= cpu_we;
              addr_r  <= cpu_addr;
              wdata_r <= cpu_wdata;
            end
          end
        end
        ST_ACCESS: begin
          // The byte read on beat k-1 arrives during beat k.
          if (!we_r && (beat_r != 2'd0)) begin
            asm_r <= {asm_r[15:0], mem_rdata};
          end
          if (beat_r == LAST_BEAT) begin
            state_r <= ST_DONE;
          end else begin
            beat_r <= beat_r + 2'd1;
          end
        end
        ST_DONE: begin
          if (!we_r) begin
            if (owner_r == OWN_DMA) begin
              dma_rdata_r <= word_s;
            end else begin
              cpu_rdata_r <= word_s;
            end
          end
          last_r  <= owner_r;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the state registers; a beat coinciding with reset is squashed.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    cpu_done  = 1'b0;
    dma_done  = 1'b0;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    word_s    = {asm_r, mem_rdata};
    cpu_rdata = cpu_rdata_r;
    dma_rdata = dma_rdata_r;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (beat_r == 2'd0) begin
          cpu_gnt = (owner_r == OWN_CPU);
          dma_gnt = (owner_r == OWN_DMA);
        end else begin
          cpu_gnt = 1'b0;
          dma_gnt = 1'b0;
        end
        if (!rst) begin
          mem_en    = 1'b1;
          mem_we    = we_r;
          mem_addr  = addr_r + AW'(beat_r);
          mem_wdata = word_byte(wdata_r, beat_r);
        end else begin
          mem_en = 1'b0;
        end
      end
      ST_DONE: begin
        busy     = 1'b1;
        cpu_done = (owner_r == OWN_CPU);
        dma_done = (owner_r == OWN_DMA);
        if (!we_r) begin
          if (owner_r == OWN_DMA) begin
            dma_rdata = word_s;
          end else begin
            cpu_rdata = word_s;
          end
        end else begin
          cpu_rdata = cpu_rdata_r;
          dma_rdata = dma_rdata_r;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-byte synchronous RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [5:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done, busy;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  ram [64];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(6), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 6'h00; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 6'h00; dma_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, cpu_gnt, dma_gnt, cpu_done, dma_done, mem_en, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {busy, cpu_gnt, dma_gnt, cpu_done, dma_done, mem_en, mem_we});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 78'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {cpu_rdata, dma_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) ram[8 + i] = exp_b[i];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h08;
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      errors++; $display("FAIL rd_gnt got %b exp 10", {cpu_gnt, dma_gnt});
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'(8 + k)}) begin
        errors++; $display("FAIL rd_beat%0d got en/we/addr %b/%b/%h exp 1/0/%h", k, mem_en, mem_we, mem_addr, 6'(8 + k));
      end
      tick();
    end
    checks++;
    if ({cpu_done, dma_done, mem_en} !== 3'b100 || cpu_rdata !== 32'h11223344) begin
      errors++; $display("FAIL rd_done got done=%b%b en=%b rdata=%h exp 10 0 11223344", cpu_done, dma_done, mem_en, cpu_rdata);
    end
    tick();
    checks++;
    if ({busy, cpu_done} !== 2'b00 || cpu_rdata !== 32'h11223344) begin
      errors++; $display("FAIL rd_hold got busy=%b done=%b rdata=%h exp 0 0 11223344", busy, cpu_done, cpu_rdata);
    end
  endtask

  task automatic test_dma_write();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 6'h10; dma_wdata = w;
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) begin
      errors++; $display("FAIL wr_gnt got %b exp 01", {cpu_gnt, dma_gnt});
    end
    dma_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'(16 + k), w[31 - 8*k -: 8]}) begin
        errors++; $display("FAIL wr_beat%0d got %b/%b/%h/%h exp 1/1/%h/%h", k, mem_en, mem_we, mem_addr, mem_wdata, 6'(16 + k), w[31 - 8*k -: 8]);
      end
      tick();
    end
    checks++;
    if ({dma_done, cpu_done} !== 2'b10 || dma_rdata !== 32'h0 || cpu_rdata !== 32'h11223344) begin
      errors++; $display("FAIL wr_done got done=%b%b dma_rdata=%h cpu_rdata=%h exp 10 0 11223344", dma_done, cpu_done, dma_rdata, cpu_rdata);
    end
    tick();
    checks++;
    if ({ram[16], ram[17], ram[18], ram[19]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_ram got %h exp deadbeef", {ram[16], ram[17], ram[18], ram[19]});
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = 6'h00; dma_addr = 6'h04;
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      errors++; $display("FAIL rr_first got %b exp 10", {cpu_gnt, dma_gnt});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({busy, cpu_gnt, dma_gnt} !== 3'b000) begin
      errors++; $display("FAIL rr_gap got %b exp 000", {busy, cpu_gnt, dma_gnt});
    end
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) begin
      errors++; $display("FAIL rr_second got %b exp 01", {cpu_gnt, dma_gnt});
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      errors++; $display("FAIL rr_third got %b exp 10", {cpu_gnt, dma_gnt});
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_a [4];
    logic [31:0] w;
    exp_a[0] = 6'h3E; exp_a[1] = 6'h3F; exp_a[2] = 6'h00; exp_a[3] = 6'h01;
    w = 32'hA1B2C3D4;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h3E; cpu_wdata = w;
    tick();
    cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_a[k], w[31 - 8*k -: 8]}) begin
        errors++; $display("FAIL wrap_beat%0d got %b/%h/%h exp 1/%h/%h", k, mem_we, mem_addr, mem_wdata, exp_a[k], w[31 - 8*k -: 8]);
      end
      tick();
    end
    tick();
    checks++;
    if ({ram[62], ram[63], ram[0], ram[1]} !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL wrap_ram got %h exp a1b2c3d4", {ram[62], ram[63], ram[0], ram[1]});
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h3E;
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL wrap_read got done=%b rdata=%h exp 1 a1b2c3d4", cpu_done, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ram[32] = 8'h00; ram[33] = 8'h00; ram[34] = 8'h99; ram[35] = 8'h98;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 6'h20; dma_wdata = 32'h55667788;
    tick();
    dma_req = 1'b0;
    tick(); tick();
    checks++;
    if (mem_addr !== 6'h22) begin
      errors++; $display("FAIL rstmid_beat2 got addr=%h exp 22", mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, dma_done, cpu_done} !== 3'b000 || cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_idle got busy/done=%b rdata=%h exp 000 0", {busy, dma_done, cpu_done}, cpu_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dma_done, busy} !== 2'b00) begin
        errors++; $display("FAIL rstmid_nodone got %b exp 00", {dma_done, busy});
      end
      tick();
    end
    checks++;
    if ({ram[32], ram[33], ram[34], ram[35]} !== 32'h55669998) begin
      errors++; $display("FAIL rstmid_ram got %h exp 55669998", {ram[32], ram[33], ram[34], ram[35]});
    end
  endtask

  task automatic test_late_dma();
    int n;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h08;
    tick();
    cpu_req = 1'b0;
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 6'h30; dma_wdata = 32'h01020304;
    tick(); tick(); tick();
    checks++;
    if ({cpu_done, dma_gnt} !== 2'b10 || cpu_rdata !== 32'h11223344) begin
      errors++; $display("FAIL late_cpu_done got done/gnt=%b rdata=%h exp 10 11223344", {cpu_done, dma_gnt}, cpu_rdata);
    end
    tick();
    checks++;
    if ({busy, dma_gnt} !== 2'b00) begin
      errors++; $display("FAIL late_idle got %b exp 00", {busy, dma_gnt});
    end
    tick();
    checks++;
    if ({dma_gnt, cpu_gnt} !== 2'b10) begin
      errors++; $display("FAIL late_dma_gnt got %b exp 10", {dma_gnt, cpu_gnt});
    end
    dma_req = 1'b0;
    n = 0;
    while (dma_done !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL late_dma_done got %0d cycles exp 4", n);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_late_dma();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
